// File: rtl/tdm_demux.sv
// tdm_demux: splits a sync-framed TDM word stream into one registered
// output word per channel; only complete, well-framed frames update dout.
module tdm_demux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               in_valid,
    input  logic                               sync,
    output logic [CHANNELS-1:0][WIDTH-1:0]     dout,
    output logic                               frame_valid,
    output logic                               locked,
    output logic                               sync_err
);

    localparam int unsigned SLOT_W = $clog2(CHANNELS);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic [WIDTH-1:0]                slot0_q, slot0_d;
    logic [CHANNELS-1:1][WIDTH-1:0]  shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  dout_q, dout_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            locked_q, locked_d;
    logic                            sync_err_q, sync_err_d;

    logic                            last_slot;
    logic                            slot_zero;

    assign last_slot = (slot_q == SLOT_W'(CHANNELS - 1));
    assign slot_zero = (slot_q == '0);

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            slot0_q       <= '0;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            slot0_q       <= slot0_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Next FSM state and slot position; bubbles leave everything unchanged
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        state_d = COLLECT;
                        slot_d  = SLOT_W'(1);
                    end
                end
                COLLECT: begin
                    if (sync) begin
                        // early sync restarts a frame, expected sync continues
                        slot_d = SLOT_W'(1);
                    end else if (slot_zero) begin
                        // missing sync: lose alignment
                        state_d = HUNT;
                        slot_d  = '0;
                    end else if (last_slot) begin
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Data capture, frame publication and status pulses
    always_comb begin
        slot0_d       = slot0_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        locked_d      = (state_d == COLLECT);
        if (in_valid) begin
            if (sync) begin
                slot0_d    = din;
                sync_err_d = (state_q == COLLECT) && !slot_zero;
            end else if (state_q == COLLECT) begin
                if (slot_zero) begin
                    sync_err_d = 1'b1;
                end else begin
                    for (int k = 1; k < int'(CHANNELS); k++) begin
                        if (slot_q == SLOT_W'(k)) begin
                            shadow_d[k] = din;
                        end
                    end
                    if (last_slot) begin
                        // final word bypasses the shadow straight into dout
                        dout_d[0] = slot0_q;
                        for (int k = 1; k < int'(CHANNELS) - 1; k++) begin
                            dout_d[k] = shadow_q[k];
                        end
                        dout_d[CHANNELS-1] = din;
                        frame_valid_d      = 1'b1;
                    end
                end
            end
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the channel-select mux path. A single WIDTH-bit word stream, in which a selector interleaves CHANNELS sources, is split back into one registered output per channel. Channel 0 of each frame is marked by `sync`. Only complete, well-framed frames reach the outputs. Sits downstream of the mux/serialiser and feeds per-channel consumers.

## Interface
- `WIDTH`, 8, bits per channel word (1..32)
- `CHANNELS`, 2, channels per frame (2..8)

- `clock`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `din`  in  WIDTH  incoming word
- `in_valid`  in  1  `din`/`sync` valid this cycle; low = bubble, ignored
- `sync`  in  1  qualified by `in_valid`; marks the channel-0 word of a frame
- `dout`  out  CHANNELS×WIDTH  packed `[CHANNELS-1:0][WIDTH-1:0]`; `dout[k]` is channel k of the last complete frame
- `frame_valid`  out  1  one-cycle pulse when `dout` is updated
- `locked`  out  1  high while aligned to frames
- `sync_err`  out  1  one-cycle pulse on a framing violation

## Operation
- Internal state: shadow registers `shadow[CHANNELS-1:1]`, slot counter `slot` of width clog2(CHANNELS), FSM {HUNT, COLLECT}.
- Reset: FSM=HUNT, `slot`=0, `shadow`=0, `dout`=0, `frame_valid`=0, `locked`=0, `sync_err`=0.
- The block only acts on cycles with `in_valid`=1. With `in_valid`=0 all state holds and both pulse outputs are 0.
- HUNT:
  - `in_valid`&`sync`: store `din` as slot 0, set `slot`=1, go to COLLECT, set `locked`=1.
  - `in_valid`&!`sync`: drop the word, stay in HUNT. No error is flagged.
- COLLECT with `slot`≠0:
  - `in_valid`&!`sync`: store `din` in `shadow[slot]`.
    - If `slot`=CHANNELS-1: load all of `dout` from slot 0 plus `shadow` in one cycle (the final word goes straight to `dout[CHANNELS-1]`), pulse `frame_valid`, set `slot`=0.
    - Otherwise set `slot`+=1.
  - `in_valid`&`sync` (early sync, short frame): pulse `sync_err`, discard the partial frame, keep `dout` unchanged. Treat this word as slot 0 of a new frame, set `slot`=1, stay in COLLECT with `locked`=1.
- COLLECT with `slot`=0 (expecting sync):
  - `in_valid`&`sync`: store slot 0, set `slot`=1.
  - `in_valid`&!`sync` (missing sync, long frame): pulse `sync_err`, drop the word, go to HUNT, set `locked`=0, set `slot`=0.
- Slot 0 is held in a dedicated register. `dout` changes only on a `frame_valid` cycle.
- `reset` asserted mid-frame takes priority over everything. The partial frame is lost and all outputs return to their reset values on the next edge.

## Timing
- Latency: `dout` and `frame_valid` update on the clock edge that accepts the last word of a frame, so they are visible 1 cycle after that word is presented.
- Back-to-back: a sync word may arrive in the cycle right after the final word. Sustained throughput is one frame per CHANNELS valid cycles.
- `sync_err` is registered and appears 1 cycle after the offending word. `sync_err` and `frame_valid` are never high in the same cycle.
- `locked` is registered: it rises the cycle after the first accepted sync and falls the cycle after a missing-sync error.
- Bubbles between words of a frame are legal and do not affect the result.

## Test plan
All scenarios use WIDTH=8, CHANNELS=2.
1. Reset, then frames (0x11 sync, 0x22), (0x33 sync, 0x44) back to back -> `dout[0]`/`dout[1]` = 0x11/0x22, then 0x33/0x44. `frame_valid` pulses once per frame, 1 cycle after the second word. `sync_err` stays 0.
2. Words 0xAA, 0xBB with no sync, then (0x01 sync, 0x02) -> 0xAA and 0xBB are dropped, `locked` stays 0 until the sync, then `dout`=0x01/0x02.
3. (0x10 sync), then (0x20 sync, 0x30) -> one `sync_err` pulse, `dout` not updated on the error, then `dout`=0x20/0x30 with a single `frame_valid`.
4. Complete frame (0x5 sync, 0x6), then 0x7 without sync -> `sync_err` pulse, `locked` falls, FSM in HUNT, `dout` holds 0x5/0x6.
5. Frame (0x9 sync, 0xC) with 3 bubble cycles between the words -> `dout`=0x09/0x0C, `frame_valid` 1 cycle after 0xC.
6. `reset` asserted after (0x77 sync), before the second word -> all outputs return to 0. A following (0x01 sync, 0x02) frame yields 0x01/0x02 normally.
